// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed LATENCY to a one-cycle response pulse.
// Optional DMEM_STATS_EN adds saturating load/store/error counters.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [15:0] stat_errors
`endif
);

    localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    logic [31:0] mem [0:DEPTH-1];

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic               w_accept;
    logic               w_err;
    logic               w_resp;

    logic               r_we;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;
    logic               r_err;

    assign w_err = (req_addr[1:0] != 2'b00) ||
                   ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                // Leave WAIT on the edge where the counter reaches zero.
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            r_we    <= req_we;
            r_idx   <= req_addr[IDX_W+1:2];
            r_wdata <= req_wdata;
            r_err   <= w_err;
        end
    end

    // Store commits on the edge leaving RESP; a reset in that cycle drops it.
    always_ff @(posedge clock) begin
        if (!reset && (r_state == RESP) && r_we && !r_err) begin
            mem[r_idx] <= r_wdata;
        end
    end

    assign req_ready = (r_state == IDLE) && !reset;
    assign w_resp    = (r_state == RESP) && !reset;
    assign rsp_valid = w_resp;
    assign rsp_err   = w_resp && r_err;
    assign rsp_rdata = (w_resp && !r_err && !r_we) ? mem[r_idx] : 32'd0;

`ifdef DMEM_STATS_EN
    logic [15:0] r_loads;
    logic [15:0] r_stores;
    logic [15:0] r_errors;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_loads  <= 16'd0;
            r_stores <= 16'd0;
            r_errors <= 16'd0;
        end else if (r_state == RESP) begin
            if (r_err) begin
                if (r_errors != 16'hFFFF) r_errors <= r_errors + 16'd1;
            end else if (r_we) begin
                if (r_stores != 16'hFFFF) r_stores <= r_stores + 16'd1;
            end else begin
                if (r_loads != 16'hFFFF) r_loads <= r_loads + 16'd1;
            end
        end
    end

    assign stat_loads  = r_loads;
    assign stat_stores = r_stores;
    assign stat_errors = r_errors;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed test-plan scenarios plus random traffic against an array model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        h_valid = 1'b0;
    logic        h_we = 1'b0;
    logic [31:0] h_addr = 32'd0;
    logic [31:0] h_wdata = 32'd0;
    logic        h_ready;
    logic        h_rsp_valid;
    logic [31:0] h_rdata;
    logic        h_err;

`ifdef DMEM_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errors;
    logic [15:0] s1_loads, s1_stores, s1_errors;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
`endif
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(h_valid), .req_ready(h_ready), .req_we(h_we),
        .req_addr(h_addr), .req_wdata(h_wdata),
        .rsp_valid(h_rsp_valid), .rsp_rdata(h_rdata), .rsp_err(h_err)
`ifdef DMEM_STATS_EN
        , .stat_loads(s1_loads), .stat_stores(s1_stores), .stat_errors(s1_errors)
`endif
    );

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    // Issue one request on dut; lat = cycles from accept cycle to the response (0 = no response).
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int rdy_low);
        int n;
        @(negedge clock);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0; rdy_low = 0; rd = 32'hDEAD_BEEF; er = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (!req_ready) rdy_low++;
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic seen;
        reset = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd0;
        h_valid = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low got=%b want=0", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        @(posedge clock);
        #1 reset = 1'b0; req_valid = 1'b0; h_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b want=1", req_ready); end
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0)
            begin failures++; $display("FAIL rsp_after_reset got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_rdata); end
        seen = 1'b0;
        repeat (5) begin @(negedge clock); seen = seen | rsp_valid | h_rsp_valid; end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL req_during_reset_ignored got_rsp=%b want=0", seen); end
    endtask

    task automatic test_load();
        logic [31:0] rd; logic er; int lat, rl;
        dut.mem[0] = 32'd42; model_mem[0] = 32'd42;
        do_txn(1'b0, 32'd0, 32'd0, rd, er, lat, rl);
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL load_latency got=%0d want=%0d", lat, LAT); end
        checks++;
        if (rl !== LAT) begin failures++; $display("FAIL load_ready_low got=%0d want=%0d", rl, LAT); end
        checks++;
        if (rd !== 32'd42 || er !== 1'b0) begin failures++; $display("FAIL load_data got=%0d err=%b want=42 err=0", rd, er); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat, rl;
        do_txn(1'b1, 32'd4, 32'd47, rd, er, lat, rl);
        model_mem[1] = 32'd47;
        checks++;
        if (lat !== LAT || rd !== 32'd0 || er !== 1'b0)
            begin failures++; $display("FAIL store_rsp got lat=%0d d=%0d e=%b want lat=%0d d=0 e=0", lat, rd, er, LAT); end
        @(negedge clock);
        checks++;
        if (dut.mem[1] !== 32'd47) begin failures++; $display("FAIL store_commit got=%0d want=47", dut.mem[1]); end
        do_txn(1'b0, 32'd4, 32'd0, rd, er, lat, rl);
        checks++;
        if (rd !== 32'd47 || er !== 1'b0) begin failures++; $display("FAIL load_after_store got=%0d e=%b want=47", rd, er); end
    endtask

    task automatic test_bad_addr();
        logic [31:0] rd; logic er; int lat, rl;
        do_txn(1'b0, 32'(4 * DEPTH), 32'd0, rd, er, lat, rl);
        checks++;
        if (lat !== LAT || er !== 1'b1 || rd !== 32'd0)
            begin failures++; $display("FAIL oob_load got lat=%0d e=%b d=%h want lat=%0d e=1 d=0", lat, er, rd, LAT); end
        do_txn(1'b1, 32'd2, 32'd99, rd, er, lat, rl);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL misaligned_store got e=%b d=%h want e=1 d=0", er, rd); end
        @(negedge clock);
        checks++;
        if (dut.mem[0] !== model_mem[0]) begin failures++; $display("FAIL misaligned_no_write got=%h want=%h", dut.mem[0], model_mem[0]); end
    endtask

    task automatic test_reset_wait();
        logic seen; int n;
        dut.mem[2] = 32'hA5A5_0002; model_mem[2] = 32'hA5A5_0002;
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd8; req_wdata = 32'd7;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        @(posedge clock);
        #1 req_valid = 1'b0; reset = 1'b1;
        seen = 1'b0;
        @(negedge clock); seen = seen | rsp_valid;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_abort got=%b want=1", req_ready); end
        repeat (5) begin seen = seen | rsp_valid; @(negedge clock); end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_rsp got=%b want=0", seen); end
        checks++;
        if (dut.mem[2] !== model_mem[2]) begin failures++; $display("FAIL abort_no_write got=%h want=%h", dut.mem[2], model_mem[2]); end
    endtask

    task automatic test_held_request();
        int acc, rsp, bad;
        logic [31:0] val;
        val = $urandom;
        dut1.mem[5] = val;
        @(negedge clock);
        h_valid = 1'b1; h_we = 1'b0; h_addr = 32'd20; h_wdata = 32'd0;
        acc = 0; rsp = 0; bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (h_ready) acc++;
            if (h_rsp_valid) begin rsp++; if (h_rdata !== val || h_err !== 1'b0) bad++; end
            @(negedge clock);
        end
        h_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (h_ready && h_valid) acc++;
            if (h_rsp_valid) begin rsp++; if (h_rdata !== val) bad++; end
            @(negedge clock);
        end
        checks++;
        if (acc !== 5) begin failures++; $display("FAIL held_accepts got=%0d want=5", acc); end
        checks++;
        if (rsp !== 5) begin failures++; $display("FAIL held_responses got=%0d want=5", rsp); end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL held_rdata bad_beats=%0d want=0", bad); end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd, exp_rd; logic er, we, exp_er; int lat, rl, sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if (sel == 0)      addr = 32'(($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3));
            else if (sel == 1) addr = 32'(4 * DEPTH + ($urandom_range(0, 1000) << 2));
            else               addr = 32'($urandom_range(0, 15) << 2);
            exp_er = addr_bad(addr);
            exp_rd = (exp_er || we) ? 32'd0 : model_mem[addr[31:2]];
            if (!exp_er && we) model_mem[addr[31:2]] = wd;
            do_txn(we, addr, wd, rd, er, lat, rl);
            checks++;
            if (lat !== LAT || rd !== exp_rd || er !== exp_er)
                begin failures++; $display("FAIL random_%0d addr=%h we=%b got lat=%0d d=%h e=%b want lat=%0d d=%h e=%b",
                                           i, addr, we, lat, rd, er, LAT, exp_rd, exp_er); end
        end
        @(negedge clock);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (dut.mem[k] !== model_mem[k])
                begin failures++; $display("FAIL random_mem_%0d got=%h want=%h", k, dut.mem[k], model_mem[k]); end
        end
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        logic [31:0] rd; logic er; int lat, rl;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({stat_loads, stat_stores, stat_errors} !== 48'd0)
            begin failures++; $display("FAIL stats_reset got l=%0d s=%0d e=%0d want 0", stat_loads, stat_stores, stat_errors); end
        for (int i = 0; i < 3; i++) do_txn(1'b0, 32'(i * 4), 32'd0, rd, er, lat, rl);
        for (int i = 0; i < 2; i++) begin
            do_txn(1'b1, 32'(64 + i * 4), 32'(i), rd, er, lat, rl);
            model_mem[16 + i] = 32'(i);
        end
        do_txn(1'b0, 32'd3, 32'd0, rd, er, lat, rl);
        @(negedge clock);
        checks++;
        if (stat_loads !== 16'd3 || stat_stores !== 16'd2 || stat_errors !== 16'd1)
            begin failures++; $display("FAIL stats_counts got l=%0d s=%0d e=%0d want 3 2 1", stat_loads, stat_stores, stat_errors); end
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({stat_loads, stat_stores, stat_errors} !== 48'd0)
            begin failures++; $display("FAIL stats_clear got l=%0d s=%0d e=%0d want 0", stat_loads, stat_stores, stat_errors); end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = $urandom;
            dut.mem[i]   = model_mem[i];
            dut1.mem[i]  = 32'd0;
        end
        test_reset();
        test_load();
        test_store_load();
        test_bad_addr();
        test_reset_wait();
        test_held_request();
        test_random();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
